// File: rtl/esc_halfduplex_uart.sv
`default_nettype none
// ============================================================================
//  Module      : esc_halfduplex_uart
//  Description : Single-wire half-duplex 8N1 UART for ESC passthrough. Sends
//                host bytes on the pad, then releases it and returns replies.
//  Revision    : 1.0 - initial release
// ============================================================================
module esc_halfduplex_uart #(
    parameter int CLK_FREQ_HZ     = 72_000_000,
    parameter int BAUD_RATE       = 19200,
    parameter int TURNAROUND_BITS = 2
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    input  logic       i_line_in,
    output logic       o_line_out,
    output logic       o_line_oe,
    output logic       o_busy,
    output logic       o_rx_overrun,
    output logic       o_frame_err
);

    localparam int c_BIT_CYC   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_HALF_CYC  = c_BIT_CYC / 2;
    localparam int c_GUARD_CYC = TURNAROUND_BITS * c_BIT_CYC;
    localparam int c_CNT_MAX   = (c_GUARD_CYC > c_BIT_CYC) ? c_GUARD_CYC : c_BIT_CYC;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LOAD   = c_CNT_W'(c_BIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LOAD  = c_CNT_W'((c_HALF_CYC > 0) ? c_HALF_CYC - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_GUARD_LOAD = c_CNT_W'((c_GUARD_CYC > 0) ? c_GUARD_CYC - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_START = 3'd1,
        ST_TX_DATA  = 3'd2,
        ST_TX_STOP  = 3'd3,
        ST_TX_GUARD = 3'd4,
        ST_RX_START = 3'd5,
        ST_RX_DATA  = 3'd6,
        ST_RX_STOP  = 3'd7
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]           r_bit_idx, w_bit_idx_nxt;
    logic                 r_sync_meta, r_rx_s, r_rx_prev;
    logic                 w_fall, w_bit_end;
    logic                 w_tx_ready, w_tx_accept, w_rx_shift_en, w_rx_stop_smp;
    logic [7:0]           r_tx_byte, r_rx_shift, r_rx_data;
    logic                 r_rx_valid, r_rx_overrun, r_frame_err;

    assign w_fall    = r_rx_prev & ~r_rx_s;
    assign w_bit_end = (r_bit_cnt == '0);

    // Pad synchroniser; idle-high reset so no spurious start edge on release
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
        end else begin
            r_sync_meta <= i_line_in;
            r_rx_s      <= r_sync_meta;
            r_rx_prev   <= r_rx_s;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt - c_CNT_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_tx_ready    = 1'b0;
        w_tx_accept   = 1'b0;
        w_rx_shift_en = 1'b0;
        w_rx_stop_smp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_ready = i_enable & r_rx_s & ~w_fall;
                if (i_enable & w_fall) begin
                    w_state_nxt   = ST_RX_START;
                    w_bit_cnt_nxt = c_HALF_LOAD;
                end else if (i_tx_valid & w_tx_ready) begin
                    w_tx_accept   = 1'b1;
                    w_state_nxt   = ST_TX_START;
                    w_bit_cnt_nxt = c_BIT_LOAD;
                end
            end
            ST_TX_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_TX_DATA;
                    w_bit_cnt_nxt = c_BIT_LOAD;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_TX_DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = c_BIT_LOAD;
                    if (r_bit_idx == 3'd7) w_state_nxt = ST_TX_STOP;
                    else w_bit_idx_nxt = r_bit_idx + 3'd1;
                end
            end
            ST_TX_STOP: begin
                // Last stop cycle doubles as the accept slot for back-to-back bytes
                if (w_bit_end) begin
                    w_tx_ready = i_enable;
                    if (i_tx_valid & i_enable) begin
                        w_tx_accept   = 1'b1;
                        w_state_nxt   = ST_TX_START;
                        w_bit_cnt_nxt = c_BIT_LOAD;
                    end else if (c_GUARD_CYC == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_TX_GUARD;
                        w_bit_cnt_nxt = c_GUARD_LOAD;
                    end
                end
            end
            ST_TX_GUARD: begin
                if (w_bit_end) w_state_nxt = ST_IDLE;
            end
            ST_RX_START: begin
                if (w_bit_end) begin
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_RX_DATA;
                        w_bit_cnt_nxt = c_BIT_LOAD;
                        w_bit_idx_nxt = '0;
                    end
                end
            end
            ST_RX_DATA: begin
                if (w_bit_end) begin
                    w_rx_shift_en = 1'b1;
                    w_bit_cnt_nxt = c_BIT_LOAD;
                    if (r_bit_idx == 3'd7) w_state_nxt = ST_RX_STOP;
                    else w_bit_idx_nxt = r_bit_idx + 3'd1;
                end
            end
            ST_RX_STOP: begin
                if (w_bit_end) begin
                    w_rx_stop_smp = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!i_enable) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_bit_idx_nxt = '0;
            w_tx_ready    = 1'b0;
            w_tx_accept   = 1'b0;
            w_rx_shift_en = 1'b0;
            w_rx_stop_smp = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_byte    <= '0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_tx_accept) r_tx_byte <= i_tx_data;
            if (w_rx_shift_en) r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
            if (!i_enable) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end else begin
                if (r_rx_valid & i_rx_ready) r_rx_valid <= 1'b0;
                if (w_rx_stop_smp) begin
                    if (!r_rx_s) begin
                        r_frame_err <= 1'b1;
                    end else if (!r_rx_valid | i_rx_ready) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_rx_overrun <= 1'b1;
                    end
                end
            end
        end
    end

    // Ready is forced low while reset is asserted, since it is combinational
    assign o_tx_ready   = w_tx_ready & i_rst_n;
    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_rx_valid;
    assign o_rx_overrun = r_rx_overrun;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_line_oe    = (r_state == ST_TX_START) || (r_state == ST_TX_DATA) ||
                          (r_state == ST_TX_STOP)  || (r_state == ST_TX_GUARD);
    assign o_line_out   = (r_state == ST_TX_START) ? 1'b0 :
                          (r_state == ST_TX_DATA)  ? r_tx_byte[r_bit_idx] : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_esc_halfduplex_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esc_halfduplex_uart
//  Description : Directed/random bench for esc_halfduplex_uart with a
//                frame-level reference model of the pad waveform.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_esc_halfduplex_uart;

    localparam int CLK_HZ = 72_000_000;
    localparam int BAUD   = 2_000_000;
    localparam int TURN   = 2;
    localparam int BC     = CLK_HZ / BAUD;
    localparam int HALF   = BC / 2;
    localparam int FR     = 10 * BC;
    localparam int GUARD  = TURN * BC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       pad_drv = 1'b1;
    logic       tx_rdy, rx_valid, line_out, line_oe, busy, overrun, ferr;
    logic [7:0] rx_data;
    logic       line_in;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_q[$];

    // Pad model: own drive is echoed back, otherwise the remote end drives
    assign line_in = line_oe ? line_out : pad_drv;

    always #5 clk = ~clk;

    esc_halfduplex_uart #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .TURNAROUND_BITS(TURN)
    ) dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_rdy),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
        .i_line_in(line_in), .o_line_out(line_out), .o_line_oe(line_oe),
        .o_busy(busy), .o_rx_overrun(overrun), .o_frame_err(ferr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Sends tx_q with valid held, checking the pad cycle by cycle against frames+guard
    task automatic tx_burst(input string tag);
        int n;
        int sent;
        int e_oe, e_line, e_rdy, e_busy, oe_cnt;
        logic hs, x_oe, x_line, x_rdy, x_busy;
        n = tx_q.size();
        sent = 0; e_oe = 0; e_line = 0; e_rdy = 0; e_busy = 0; oe_cnt = 0;
        tx_data  = tx_q[0];
        tx_valid = 1'b1;
        chk({tag, "_ready_idle"}, tx_rdy, 1);
        step();
        sent = 1;
        if (sent < n) tx_data = tx_q[sent];
        else tx_valid = 1'b0;
        for (int i = 0; i < n * FR + GUARD + 4; i++) begin
            if (i < n * FR) begin
                x_oe = 1'b1; x_busy = 1'b1;
                x_line = frame_bit(tx_q[i / FR], (i % FR) / BC);
                x_rdy = ((i % FR) == FR - 1);
            end else if (i < n * FR + GUARD) begin
                x_oe = 1'b1; x_line = 1'b1; x_rdy = 1'b0; x_busy = 1'b1;
            end else begin
                x_oe = 1'b0; x_line = 1'b1; x_rdy = 1'b1; x_busy = 1'b0;
            end
            if (line_oe !== x_oe) e_oe++;
            if (line_out !== x_line) e_line++;
            if (tx_rdy !== x_rdy) e_rdy++;
            if (busy !== x_busy) e_busy++;
            if (line_oe) oe_cnt++;
            hs = tx_valid & tx_rdy;
            step();
            if (hs) begin
                sent++;
                if (sent < n) tx_data = tx_q[sent];
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        chk({tag, "_bytes_sent"}, sent, n);
        chk({tag, "_oe_err_cycles"}, e_oe, 0);
        chk({tag, "_line_err_cycles"}, e_line, 0);
        chk({tag, "_ready_err_cycles"}, e_rdy, 0);
        chk({tag, "_busy_err_cycles"}, e_busy, 0);
        chk({tag, "_oe_total"}, oe_cnt, n * FR + GUARD);
    endtask

    // Remote end sends one frame; reports when rx_valid rose (relative to the start edge)
    task automatic rx_frame(input logic [7:0] b, input logic stop,
                            output int valid_at, output int ferr_n, output int oe_n);
        logic v_prev;
        int   k;
        v_prev = rx_valid;
        valid_at = -1; ferr_n = 0; oe_n = 0;
        for (int i = 0; i < FR; i++) begin
            k = i / BC;
            pad_drv = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : stop;
            step();
            if (rx_valid && !v_prev && valid_at < 0) valid_at = i + 1;
            v_prev = rx_valid;
            if (ferr) ferr_n++;
            if (line_oe) oe_n++;
        end
        pad_drv = 1'b1;
    endtask

    initial begin
        logic [7:0] b0, b1;
        int va, fe, oe_n, hold, vcnt, fcnt;
        logic busy_early;

        // Reset state, enable already high
        enable = 1'b1;
        step(3);
        chk("rst_oe", line_oe, 0);
        chk("rst_out", line_out, 1);
        chk("rst_ready", tx_rdy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", ferr, 0);
        rst_n = 1'b1;
        step(3);
        chk("idle_ready", tx_rdy, 1);

        // Single byte, back-to-back pair, random burst
        tx_q = '{8'hA5};
        tx_burst("tx_a5");
        step(5);
        tx_q = '{8'h00, 8'hFF};
        tx_burst("tx_b2b");
        step(5);
        tx_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        tx_burst("tx_rand");
        step(5);

        // Reception with handshake
        for (int r = 0; r < 2; r++) begin
            b0 = (r == 0) ? 8'h3C : 8'($urandom);
            rx_frame(b0, 1'b1, va, fe, oe_n);
            chk("rx_valid_latency", va, 3 + HALF + 9 * BC);
            chk("rx_data", rx_data, b0);
            chk("rx_no_frame_err", fe, 0);
            chk("rx_oe_low", oe_n, 0);
            hold = $urandom_range(3, 20);
            step(hold);
            chk("rx_valid_hold", rx_valid, 1);
            chk("rx_data_hold", rx_data, b0);
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
            chk("rx_valid_clear", rx_valid, 0);
            step(BC);
        end

        // Short glitch is rejected at the half-bit sample
        vcnt = 0; fcnt = 0; busy_early = 1'b0;
        for (int i = 0; i < 4 * HALF; i++) begin
            pad_drv = (i < HALF / 2) ? 1'b0 : 1'b1;
            step();
            if (i + 1 == 5) busy_early = busy;
            if (rx_valid) vcnt++;
            if (ferr) fcnt++;
        end
        chk("glitch_busy_entered", busy_early, 1);
        chk("glitch_busy_done", busy, 0);
        chk("glitch_no_valid", vcnt, 0);
        chk("glitch_no_ferr", fcnt, 0);

        // Stop bit 0
        rx_frame(8'($urandom), 1'b0, va, fe, oe_n);
        chk("ferr_pulses", fe, 1);
        chk("ferr_no_valid", va, -1);
        chk("ferr_valid_low", rx_valid, 0);
        step(BC);

        // Overrun: second byte arrives while first is still unread
        b0 = 8'h11; b1 = 8'h22;
        rx_frame(b0, 1'b1, va, fe, oe_n);
        chk("ovr_first_data", rx_data, b0);
        chk("ovr_not_yet", overrun, 0);
        rx_frame(b1, 1'b1, va, fe, oe_n);
        step(4);
        chk("ovr_data_kept", rx_data, b0);
        chk("ovr_valid_kept", rx_valid, 1);
        chk("ovr_sticky", overrun, 1);
        enable = 1'b0;
        step();
        chk("dis_rx_valid", rx_valid, 0);
        chk("dis_overrun", overrun, 0);
        enable = 1'b1;
        step(BC);

        // Enable dropped mid-data, then a clean frame
        tx_data = 8'($urandom);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step(3 * BC + 5);
        chk("middis_oe_before", line_oe, 1);
        enable = 1'b0;
        step();
        chk("middis_oe", line_oe, 0);
        chk("middis_busy", busy, 0);
        chk("middis_out", line_out, 1);
        chk("middis_ready", tx_rdy, 0);
        step(5);
        enable = 1'b1;
        step(2 * BC);
        tx_q = '{8'h5A};
        tx_burst("tx_after_dis");
        step(5);

        // Reset mid-data, then a clean frame
        tx_data = 8'($urandom);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step(4 * BC);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe", line_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out", line_out, 1);
        chk("midrst_ready", tx_rdy, 0);
        step(3);
        rst_n = 1'b1;
        step(3);
        tx_q = '{8'h5A};
        tx_burst("tx_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
